// File: rtl/mole_scheduler.sv
// Whack-a-mole game-flow controller: picks mole holes from a free-running LFSR,
// times each mole's visibility window and turns guess feedback into hits/misses.
module mole_scheduler #(
    parameter int TICK_DIV   = 50000000,
    parameter int BASE_TICKS = 8,
    parameter int MIN_TICKS  = 2,
    parameter int GAP_TICKS  = 2,
    parameter int MAX_MISSES = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [7:0] score,
    input  logic       guess_correct,
    input  logic       guess_wrong,
    output logic [2:0] mole_pos,
    output logic       mole_change,
    output logic       mole_visible,
    output logic [1:0] misses,
    output logic       game_over
);

    localparam int DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);
    localparam logic signed [8:0] BASE_S = 9'(BASE_TICKS);
    localparam logic signed [8:0] MIN_S  = 9'(MIN_TICKS);
    localparam logic [7:0] GAP_LOAD   = 8'(GAP_TICKS);
    localparam logic [1:0] MISS_LIMIT = 2'(MAX_MISSES);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_SPAWN = 3'd1;
    localparam logic [2:0] S_UP    = 3'd2;
    localparam logic [2:0] S_GAP   = 3'd3;
    localparam logic [2:0] S_OVER  = 3'd4;

    logic [2:0]        state;
    logic [2:0]        next_state;
    logic [7:0]        lfsr;
    logic              lfsr_fb;
    logic [DIV_W-1:0]  div_cnt;
    logic              tick;
    logic [7:0]        life_cnt;
    logic [7:0]        gap_cnt;
    logic              gc_q;
    logic              gw_q;
    logic              hit;
    logic              wrong;
    logic              timeout;
    logic              miss_event;
    logic [1:0]        misses_inc;
    logic signed [8:0] life_raw;
    logic [7:0]        life_val;
    logic [2:0]        cand;

    assign lfsr_fb    = lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3];
    assign tick       = (div_cnt == DIV_LAST);
    assign hit        = guess_correct & ~gc_q;
    assign wrong      = guess_wrong & ~gw_q;
    assign timeout    = tick && (life_cnt == 8'd1);
    // A hit always wins over a simultaneous wrong guess or timeout.
    assign miss_event = (state == S_UP) && !hit && (wrong || timeout);
    assign misses_inc = misses + 2'd1;

    assign mole_visible = (state == S_UP);
    assign game_over    = (state == S_OVER);

    // Signed so a large score drives the raw lifetime negative instead of wrapping.
    always_comb begin
        life_raw = BASE_S - $signed({3'b000, score[7:2]});
        life_val = (life_raw < MIN_S) ? MIN_S[7:0] : life_raw[7:0];
    end

    always_comb begin
        cand = lfsr[2:0];
        if (cand == mole_pos) begin
            cand = lfsr[2:0] + 3'd1;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:  if (start) next_state = S_SPAWN;
            S_SPAWN: next_state = S_UP;
            S_UP: begin
                if (hit) begin
                    next_state = S_GAP;
                end else if (miss_event) begin
                    next_state = (misses_inc == MISS_LIMIT) ? S_OVER : S_GAP;
                end
            end
            S_GAP:   if (tick && (gap_cnt == 8'd1)) next_state = S_SPAWN;
            S_OVER:  if (start) next_state = S_SPAWN;
            default: next_state = S_IDLE;
        endcase
    end

    // mole_pos is registered on entry to SPAWN so it is valid alongside the strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            lfsr        <= 8'hA5;
            div_cnt     <= '0;
            life_cnt    <= 8'd0;
            gap_cnt     <= 8'd0;
            gc_q        <= 1'b0;
            gw_q        <= 1'b0;
            mole_pos    <= 3'd0;
            mole_change <= 1'b0;
            misses      <= 2'd0;
        end else begin
            state <= next_state;
            lfsr  <= {lfsr[6:0], lfsr_fb};
            gc_q  <= guess_correct;
            gw_q  <= guess_wrong;

            if ((next_state != state) || tick) begin
                div_cnt <= '0;
            end else begin
                div_cnt <= div_cnt + 1'b1;
            end

            mole_change <= (next_state == S_SPAWN);
            if (next_state == S_SPAWN) begin
                mole_pos <= cand;
            end

            if (state == S_SPAWN) begin
                life_cnt <= life_val;
            end else if ((state == S_UP) && tick && (next_state == S_UP)) begin
                life_cnt <= life_cnt - 8'd1;
            end

            if ((state != S_GAP) && (next_state == S_GAP)) begin
                gap_cnt <= GAP_LOAD;
            end else if ((state == S_GAP) && tick) begin
                gap_cnt <= gap_cnt - 8'd1;
            end

            if ((state == S_OVER) && start) begin
                misses <= 2'd0;
            end else if (miss_event) begin
                misses <= misses_inc;
            end
        end
    end

endmodule

// File: tb/tb_mole_scheduler.sv
// Directed self-checking bench for mole_scheduler with TICK_DIV=4 (UP = 4*life cycles,
// GAP = 8 cycles). Inputs are driven and outputs sampled on the falling clock edge.
module tb_mole_scheduler;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [7:0] score;
    logic       guess_correct;
    logic       guess_wrong;
    logic [2:0] mole_pos;
    logic       mole_change;
    logic       mole_visible;
    logic [1:0] misses;
    logic       game_over;

    int tests_run    = 0;
    int tests_failed = 0;

    mole_scheduler #(
        .TICK_DIV   (4),
        .BASE_TICKS (8),
        .MIN_TICKS  (2),
        .GAP_TICKS  (2),
        .MAX_MISSES (3)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .score         (score),
        .guess_correct (guess_correct),
        .guess_wrong   (guess_wrong),
        .mole_pos      (mole_pos),
        .mole_change   (mole_change),
        .mole_visible  (mole_visible),
        .misses        (misses),
        .game_over     (game_over)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Returns the number of falling edges until mole_change is seen, or -1 on timeout.
    task automatic wait_change(output int n);
        n = 0;
        while (mole_change !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (mole_change !== 1'b1) n = -1;
    endtask

    task automatic measure_up(output int n);
        n = 0;
        while (mole_visible === 1'b1 && n < 500) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; score = 8'd0;
        guess_correct = 1'b0; guess_wrong = 1'b0;
        step(2);
        tests_run++; if (mole_pos !== 3'd0) begin tests_failed++; $display("[TB] FAIL reset_pos: got %0d expected 0", mole_pos); end
        tests_run++; if (mole_change !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_change: got %0d expected 0", mole_change); end
        tests_run++; if (mole_visible !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_visible: got %0d expected 0", mole_visible); end
        tests_run++; if (misses !== 2'd0) begin tests_failed++; $display("[TB] FAIL reset_misses: got %0d expected 0", misses); end
        tests_run++; if (game_over !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_game_over: got %0d expected 0", game_over); end
        tests_run++; if (dut.lfsr !== 8'hA5) begin tests_failed++; $display("[TB] FAIL reset_lfsr: got %h expected a5", dut.lfsr); end
        rst_n = 1'b1;
        step(3);
        tests_run++; if (mole_change !== 1'b0 || mole_visible !== 1'b0) begin tests_failed++; $display("[TB] FAIL idle_quiet: change %0d visible %0d expected 0 0", mole_change, mole_visible); end
    endtask

    task automatic test_start_timeout();
        int n;
        logic [2:0] first_pos;
        start = 1'b1;
        step(1);
        tests_run++; if (mole_change !== 1'b1) begin tests_failed++; $display("[TB] FAIL start_strobe: got %0d expected 1", mole_change); end
        start = 1'b0;
        first_pos = mole_pos;
        step(1);
        tests_run++; if (mole_change !== 1'b0 || mole_visible !== 1'b1) begin tests_failed++; $display("[TB] FAIL strobe_width: change %0d visible %0d expected 0 1", mole_change, mole_visible); end
        tests_run++; if (misses !== 2'd0) begin tests_failed++; $display("[TB] FAIL misses_during_up: got %0d expected 0", misses); end
        measure_up(n);
        tests_run++; if (n !== 32) begin tests_failed++; $display("[TB] FAIL up_len_score0: got %0d expected 32", n); end
        tests_run++; if (misses !== 2'd1) begin tests_failed++; $display("[TB] FAIL timeout_miss: got %0d expected 1", misses); end
        wait_change(n);
        tests_run++; if (n !== 8) begin tests_failed++; $display("[TB] FAIL gap_len: got %0d expected 8", n); end
        tests_run++; if (mole_pos === first_pos) begin tests_failed++; $display("[TB] FAIL pos_differs: got %0d expected not %0d", mole_pos, first_pos); end
    endtask

    task automatic test_hit();
        int n;
        logic [2:0] prev_pos;
        prev_pos = mole_pos;
        step(6);
        guess_correct = 1'b1;
        step(1);
        tests_run++; if (mole_visible !== 1'b0) begin tests_failed++; $display("[TB] FAIL hit_drop: got %0d expected 0", mole_visible); end
        tests_run++; if (misses !== 2'd1) begin tests_failed++; $display("[TB] FAIL hit_misses: got %0d expected 1", misses); end
        step(2);
        guess_correct = 1'b0;
        // Two GAP cycles have already elapsed, so six remain before the next strobe.
        wait_change(n);
        tests_run++; if (n !== 6) begin tests_failed++; $display("[TB] FAIL hit_gap_len: got %0d expected 6", n); end
        tests_run++; if (misses !== 2'd1) begin tests_failed++; $display("[TB] FAIL hit_single: got %0d expected 1", misses); end
        tests_run++; if (mole_pos === prev_pos) begin tests_failed++; $display("[TB] FAIL hit_pos_differs: got %0d expected not %0d", mole_pos, prev_pos); end
    endtask

    task automatic test_hit_on_timeout();
        int n;
        step(32);
        tests_run++; if (mole_visible !== 1'b1) begin tests_failed++; $display("[TB] FAIL last_up_cycle: got %0d expected 1", mole_visible); end
        guess_correct = 1'b1;
        step(1);
        guess_correct = 1'b0;
        tests_run++; if (mole_visible !== 1'b0) begin tests_failed++; $display("[TB] FAIL timeout_hit_drop: got %0d expected 0", mole_visible); end
        tests_run++; if (misses !== 2'd1) begin tests_failed++; $display("[TB] FAIL timeout_hit_misses: got %0d expected 1", misses); end
        wait_change(n);
        tests_run++; if (n !== 8) begin tests_failed++; $display("[TB] FAIL timeout_hit_gap: got %0d expected 8", n); end
    endtask

    task automatic test_game_over();
        int n;
        int changes;
        int pos_moves;
        logic [2:0] hold_pos;
        step(3);
        guess_wrong = 1'b1;
        step(1);
        guess_wrong = 1'b0;
        tests_run++; if (mole_visible !== 1'b0 || misses !== 2'd2) begin tests_failed++; $display("[TB] FAIL wrong_miss: visible %0d misses %0d expected 0 2", mole_visible, misses); end
        wait_change(n);
        tests_run++; if (n !== 8) begin tests_failed++; $display("[TB] FAIL wrong_gap: got %0d expected 8", n); end
        step(1);
        measure_up(n);
        tests_run++; if (n !== 32) begin tests_failed++; $display("[TB] FAIL third_up_len: got %0d expected 32", n); end
        tests_run++; if (game_over !== 1'b1 || misses !== 2'd3) begin tests_failed++; $display("[TB] FAIL game_over_set: over %0d misses %0d expected 1 3", game_over, misses); end
        hold_pos = mole_pos;
        changes = 0;
        pos_moves = 0;
        for (int i = 0; i < 100; i++) begin
            step(1);
            if (mole_change === 1'b1 || mole_visible !== 1'b0 || game_over !== 1'b1) changes++;
            if (mole_pos !== hold_pos) pos_moves++;
        end
        tests_run++; if (changes !== 0) begin tests_failed++; $display("[TB] FAIL over_quiet: got %0d bad cycles expected 0", changes); end
        tests_run++; if (pos_moves !== 0) begin tests_failed++; $display("[TB] FAIL over_pos_hold: got %0d moves expected 0", pos_moves); end
        start = 1'b1;
        step(1);
        start = 1'b0;
        tests_run++; if (mole_change !== 1'b1 || game_over !== 1'b0 || misses !== 2'd0) begin tests_failed++; $display("[TB] FAIL restart: change %0d over %0d misses %0d expected 1 0 0", mole_change, game_over, misses); end
    endtask

    task automatic test_hit_and_wrong();
        step(4);
        guess_correct = 1'b1;
        guess_wrong   = 1'b1;
        step(1);
        guess_correct = 1'b0;
        guess_wrong   = 1'b0;
        tests_run++; if (mole_visible !== 1'b0 || misses !== 2'd0) begin tests_failed++; $display("[TB] FAIL hit_wins_wrong: visible %0d misses %0d expected 0 0", mole_visible, misses); end
    endtask

    task automatic test_difficulty();
        int n;
        score = 8'd8;
        wait_change(n);
        tests_run++; if (n !== 8) begin tests_failed++; $display("[TB] FAIL diff_gap: got %0d expected 8", n); end
        step(4);
        score = 8'd255;
        measure_up(n);
        // Three UP cycles passed before measuring; the later score change must not shorten the window.
        tests_run++; if (n + 3 !== 24) begin tests_failed++; $display("[TB] FAIL up_len_score8: got %0d expected 24", n + 3); end
        score = 8'd40;
        wait_change(n);
        step(1);
        measure_up(n);
        tests_run++; if (n !== 8) begin tests_failed++; $display("[TB] FAIL up_len_score40: got %0d expected 8", n); end
        tests_run++; if (misses !== 2'd2) begin tests_failed++; $display("[TB] FAIL diff_misses: got %0d expected 2", misses); end
        score = 8'd255;
        wait_change(n);
        step(1);
        measure_up(n);
        tests_run++; if (n !== 8) begin tests_failed++; $display("[TB] FAIL up_len_score255: got %0d expected 8", n); end
        tests_run++; if (game_over !== 1'b1) begin tests_failed++; $display("[TB] FAIL diff_game_over: got %0d expected 1", game_over); end
    endtask

    task automatic test_reset_mid_up();
        int n;
        int changes;
        score = 8'd0;
        start = 1'b1;
        step(1);
        start = 1'b0;
        step(2);
        guess_wrong = 1'b1;
        step(1);
        guess_wrong = 1'b0;
        tests_run++; if (misses !== 2'd1) begin tests_failed++; $display("[TB] FAIL pre_reset_miss: got %0d expected 1", misses); end
        wait_change(n);
        step(3);
        #2 rst_n = 1'b0;
        #1;
        tests_run++; if (mole_visible !== 1'b0 || mole_change !== 1'b0 || game_over !== 1'b0) begin tests_failed++; $display("[TB] FAIL async_reset_flags: visible %0d change %0d over %0d expected 0 0 0", mole_visible, mole_change, game_over); end
        tests_run++; if (misses !== 2'd0 || mole_pos !== 3'd0) begin tests_failed++; $display("[TB] FAIL async_reset_regs: misses %0d pos %0d expected 0 0", misses, mole_pos); end
        tests_run++; if (dut.lfsr !== 8'hA5) begin tests_failed++; $display("[TB] FAIL async_reset_lfsr: got %h expected a5", dut.lfsr); end
        @(negedge clk);
        rst_n = 1'b1;
        changes = 0;
        for (int i = 0; i < 5; i++) begin
            step(1);
            if (mole_change === 1'b1 || mole_visible === 1'b1) changes++;
        end
        tests_run++; if (changes !== 0) begin tests_failed++; $display("[TB] FAIL post_reset_idle: got %0d active cycles expected 0", changes); end
        start = 1'b1;
        step(1);
        start = 1'b0;
        tests_run++; if (mole_change !== 1'b1) begin tests_failed++; $display("[TB] FAIL post_reset_start: got %0d expected 1", mole_change); end
    endtask

    initial begin
        test_reset();
        test_start_timeout();
        test_hit();
        test_hit_on_timeout();
        test_game_over();
        test_hit_and_wrong();
        test_difficulty();
        test_reset_mid_up();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
